// File: rtl/bp_recovery_ctrl_if.sv
// Bundles the decode-stage push, memory-stage resolve and recovery/update outputs
// exchanged between the pipeline and the branch recovery controller.
interface bp_recovery_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             branchD;
  logic             pred_takeD;
  logic [31:0]      pred_targetD;
  logic [31:0]      pcD;
  logic             stallD;
  logic             flushD;
  logic             branchM;
  logic             actual_takeM;
  logic [31:0]      actual_targetM;
  logic             q_full;
  logic             flush_o;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_take;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic             q_err;

  modport master (
    output branchD, pred_takeD, pred_targetD, pcD, stallD, flushD,
           branchM, actual_takeM, actual_targetM,
    input  q_full, flush_o, redirect_valid, redirect_pc, upd_valid,
           upd_pc, upd_take, branch_cnt, mispred_cnt, q_err
  );

  modport slave (
    input  branchD, pred_takeD, pred_targetD, pcD, stallD, flushD,
           branchM, actual_takeM, actual_targetM,
    output q_full, flush_o, redirect_valid, redirect_pc, upd_valid,
           upd_pc, upd_take, branch_cnt, mispred_cnt, q_err
  );
endinterface

// File: rtl/bp_recovery_ctrl.sv
// Tracks predicted branches from D to M in a circular queue, detects mispredicts,
// drives a one-cycle flush/redirect, and emits predictor updates and statistics.
module bp_recovery_ctrl #(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  bp_recovery_ctrl_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      count_q;
  logic [31:0]      redirect_pc_q;
  logic             upd_valid_q, upd_take_q, q_err_q;
  logic [31:0]      upd_pc_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  logic [31:0]      pc_mem   [QDEPTH];
  logic             take_mem [QDEPTH];
  logic [31:0]      tgt_mem  [QDEPTH];

  logic        run, push, pop, empty, full, push_ok, pop_ok, mispred;
  logic [31:0] head_pc, head_tgt;
  logic        head_take;

  assign run     = (state_q == RUN);
  assign push    = bus.branchD & ~bus.stallD & ~bus.flushD & run;
  assign pop     = bus.branchM & run;
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(QDEPTH));
  assign pop_ok  = pop & ~empty;
  // A full queue still has room when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);

  // An empty-queue pop is checked against a not-taken entry at PC 0.
  assign head_pc   = empty ? 32'd0 : pc_mem[rd_ptr_q];
  assign head_take = empty ? 1'b0  : take_mem[rd_ptr_q];
  assign head_tgt  = empty ? 32'd0 : tgt_mem[rd_ptr_q];

  assign mispred = (head_take != bus.actual_takeM) |
                   (head_take & bus.actual_takeM & (head_tgt != bus.actual_targetM));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pop && mispred) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q]   <= bus.pcD;
      take_mem[wr_ptr_q] <= bus.pred_takeD;
      tgt_mem[wr_ptr_q]  <= bus.pred_targetD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_take_q    <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      q_err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= pop;
      if ((pop && empty) || (push && full && !pop)) q_err_q <= 1'b1;

      if (pop && mispred) begin
        // Everything behind the mispredicted branch is wrong-path.
        rd_ptr_q      <= '0;
        wr_ptr_q      <= '0;
        count_q       <= '0;
        redirect_pc_q <= bus.actual_takeM ? bus.actual_targetM : head_pc + 32'd4;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
        else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
      end

      if (pop) begin
        upd_pc_q   <= head_pc;
        upd_take_q <= bus.actual_takeM;
        if (!(&branch_cnt_q)) branch_cnt_q <= branch_cnt_q + 1'b1;
        if (mispred && !(&mispred_cnt_q)) mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
    end
  end

  assign bus.q_full         = full & ~pop;
  assign bus.flush_o        = (state_q == FLUSH);
  assign bus.redirect_valid = (state_q == FLUSH);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_take       = upd_take_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;
  assign bus.q_err          = q_err_q;
endmodule

// File: tb/tb_bp_recovery_ctrl.sv
// Directed scenarios for bp_recovery_ctrl; update and redirect responses are
// queued at issue and matched by an independent monitor.
module tb_bp_recovery_ctrl;
  localparam int QDEPTH = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        take;
  } upd_t;

  upd_t        exp_upd[$];
  logic [31:0] exp_redir[$];

  bp_recovery_ctrl_if #(.CNT_W(CNT_W)) bus ();

  bp_recovery_ctrl #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic cyc(input logic bd, input logic pt, input logic [31:0] ptg,
                     input logic [31:0] pcd, input logic st, input logic fl,
                     input logic bm, input logic at, input logic [31:0] atg);
    bus.branchD        = bd;
    bus.pred_takeD     = pt;
    bus.pred_targetD   = ptg;
    bus.pcD            = pcd;
    bus.stallD         = st;
    bus.flushD         = fl;
    bus.branchM        = bm;
    bus.actual_takeM   = at;
    bus.actual_targetM = atg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_d(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    cyc(1, pt, tgt, pc, 0, 0, 0, 0, 0);
  endtask

  // Resolve at M and record the response the monitor must see next cycle.
  task automatic pop_m(input logic at, input logic [31:0] atg,
                       input logic [31:0] exp_pc, input logic mis, input logic [31:0] exp_rpc);
    upd_t u;
    u.pc   = exp_pc;
    u.take = at;
    exp_upd.push_back(u);
    if (mis) exp_redir.push_back(exp_rpc);
    cyc(0, 0, 0, 0, 0, 0, 1, at, atg);
  endtask

  always @(negedge clk) begin
    if (bus.upd_valid === 1'b1) begin
      if (exp_upd.size() == 0) begin
        check("unexpected_upd_valid", 32'd1, 32'd0);
      end else begin
        upd_t u;
        u = exp_upd.pop_front();
        check("upd_pc", bus.upd_pc, u.pc);
        check("upd_take", {31'd0, bus.upd_take}, {31'd0, u.take});
      end
    end
    if (bus.redirect_valid === 1'b1) begin
      if (exp_redir.size() == 0) begin
        check("unexpected_redirect", 32'd1, 32'd0);
      end else begin
        check("redirect_pc", bus.redirect_pc, exp_redir.pop_front());
        check("flush_with_redirect", {31'd0, bus.flush_o}, 32'd1);
      end
    end else if (bus.flush_o === 1'b1) begin
      check("flush_without_redirect", 32'd1, 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    check("rst_flush_o", {31'd0, bus.flush_o}, 32'd0);
    check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_upd_valid", {31'd0, bus.upd_valid}, 32'd0);
    check("rst_upd_pc", bus.upd_pc, 32'd0);
    check("rst_q_full", {31'd0, bus.q_full}, 32'd0);
    check("rst_q_err", {31'd0, bus.q_err}, 32'd0);
    check("rst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    check("rst_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);

    // Correct taken prediction
    push_d(32'h100, 1, 32'h200);
    pop_m(1, 32'h200, 32'h100, 0, 0);
    check("t1_branch_cnt", 32'(bus.branch_cnt), 32'd1);
    check("t1_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
    check("t1_no_flush", {31'd0, bus.flush_o}, 32'd0);
    idle();

    // Direction mispredict
    push_d(32'h104, 0, 32'h0);
    pop_m(1, 32'h300, 32'h104, 1, 32'h300);
    check("t2_mispred_cnt", 32'(bus.mispred_cnt), 32'd1);
    check("t2_branch_cnt", 32'(bus.branch_cnt), 32'd2);
    idle();

    // Target mispredict with wrong-path push alongside the pop
    push_d(32'h10, 1, 32'h40);
    push_d(32'h20, 0, 32'h0);
    exp_upd.push_back('{pc: 32'h10, take: 1'b1});
    exp_redir.push_back(32'h80);
    cyc(1, 0, 0, 32'h30, 0, 0, 1, 1, 32'h80);
    check("t3_branch_cnt", 32'(bus.branch_cnt), 32'd3);
    check("t3_mispred_cnt", 32'(bus.mispred_cnt), 32'd2);
    idle();

    // Fill, overflow, then interleave across pointer wrap
    for (int i = 0; i < QDEPTH; i++) begin
      push_d(32'h1000 + 32'(4 * i), 0, 0);
      if (i == QDEPTH - 2) check("t4_not_full", {31'd0, bus.q_full}, 32'd0);
    end
    check("t4_full", {31'd0, bus.q_full}, 32'd1);
    check("t4_no_err_yet", {31'd0, bus.q_err}, 32'd0);
    push_d(32'h2000, 0, 0);
    check("t4_overflow_err", {31'd0, bus.q_err}, 32'd1);
    check("t4_still_full", {31'd0, bus.q_full}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] epc;
      epc = (i < QDEPTH) ? 32'h1000 + 32'(4 * i) : 32'h3000 + 32'(4 * (i - QDEPTH));
      exp_upd.push_back('{pc: epc, take: 1'b0});
      cyc(1, 0, 0, 32'h3000 + 32'(4 * i), 0, 0, 1, 0, 0);
      if (i == 0) check("t4_full_masked_by_pop", {31'd0, bus.q_full}, 32'd0);
    end
    idle();
    check("t4_refull", {31'd0, bus.q_full}, 32'd1);
    for (int j = 0; j < QDEPTH; j++) pop_m(0, 0, 32'h3018 + 32'(4 * j), 0, 0);
    check("t4_branch_sat", 32'(bus.branch_cnt), 32'd15);
    check("t4_mispred_cnt", 32'(bus.mispred_cnt), 32'd2);
    idle();

    // Stall and flush gating
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 32'h500, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 32'h500, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 32'h600, 0, 1, 0, 0, 0);
    pop_m(0, 0, 32'h500, 0, 0);
    pop_m(0, 0, 32'h0, 0, 0);
    pop_m(0, 0, 32'h0, 0, 0);
    check("t5_branch_sat", 32'(bus.branch_cnt), 32'd15);
    check("t5_mispred_cnt", 32'(bus.mispred_cnt), 32'd2);
    check("t5_q_err_sticky", {31'd0, bus.q_err}, 32'd1);
    idle();

    // Mispredict, then reset during the flush cycle
    push_d(32'h700, 1, 32'h740);
    pop_m(0, 0, 32'h700, 1, 32'h704);
    check("t6_mispred_cnt", 32'(bus.mispred_cnt), 32'd3);
    check("t6_in_flush", {31'd0, bus.flush_o}, 32'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("t6_flush_cleared", {31'd0, bus.flush_o}, 32'd0);
    check("t6_redirect_cleared", {31'd0, bus.redirect_valid}, 32'd0);
    check("t6_branch_cnt", 32'(bus.branch_cnt), 32'd0);
    check("t6_mispred_cnt0", 32'(bus.mispred_cnt), 32'd0);
    check("t6_q_err", {31'd0, bus.q_err}, 32'd0);
    check("t6_q_full", {31'd0, bus.q_full}, 32'd0);
    idle();
    idle();

    check("pending_upd", 32'(exp_upd.size()), 32'd0);
    check("pending_redirect", 32'(exp_redir.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_recovery_ctrl.md
Name: bp_recovery_ctrl

Overview:
- Sequences branch-prediction bookkeeping between decode and memory stage of the 5-stage MIPS pipeline.
- Records every predicted branch leaving D in an in-flight queue and checks it against the resolved outcome at M.
- On a mispredict it drives pipeline flush and PC redirect, and discards wrong-path entries.
- Issues one predictor-update command per resolved branch to the local predictor and keeps saturating performance counters.

Parameters:
- QDEPTH, 4, in-flight queue entries; power of 2, minimum 2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- branchD  in  1  D-stage instruction is a branch
- pred_takeD  in  1  predictor taken decision for D-stage branch
- pred_targetD  in  32  predicted target; don't-care when not taken
- pcD  in  32  PC of D-stage instruction
- stallD  in  1  D stage stalled
- flushD  in  1  external D flush (exception or jump)
- branchM  in  1  M-stage branch resolved this cycle
- actual_takeM  in  1  resolved direction
- actual_targetM  in  32  resolved target
- q_full  out  1  queue full; pipeline must stall D
- flush_o  out  1  flush F/D/E
- redirect_valid  out  1  load redirect_pc into PC
- redirect_pc  out  32  corrected fetch address
- upd_valid  out  1  predictor update strobe
- upd_pc  out  32  PC of resolved branch
- upd_take  out  1  resolved direction for predictor
- branch_cnt  out  CNT_W  resolved branches
- mispred_cnt  out  CNT_W  mispredicted branches
- q_err  out  1  sticky: pop with empty queue or push while full

Behaviour:
- Reset: synchronous, active-high on rst, clock clk. Queue empty, pointers 0, state RUN. All outputs 0 except q_full, which is combinational from count and so also 0.
- Entry fields: pc[31:0], pred_take, pred_target[31:0]. Storage uses circular read/write pointers of log2(QDEPTH) bits that wrap modulo QDEPTH, plus a count of log2(QDEPTH)+1 bits.
- push = branchD & ~stallD & ~flushD & (state==RUN).
- pop = branchM & (state==RUN).
- Push while full: entry dropped, q_err set.
- Pop while empty: compare against {pc=0, pred_take=0}, q_err set, no pointer change.
- Push and pop in the same cycle are allowed; count is unchanged; a full queue accepts a push when a pop happens in the same cycle.
- q_full = (count==QDEPTH) & ~pop. It is combinational.
- Mispredict at pop:
  - (head.pred_take != actual_takeM), or
  - (head.pred_take & actual_takeM & head.pred_target != actual_targetM).
- State RUN:
  - On pop with mispredict, the next state is FLUSH.
  - In that same cycle the queue is cleared: pointers and count go to 0.
  - Any simultaneous push is discarded, because it is wrong-path.
- State FLUSH (exactly one cycle):
  - flush_o=1, redirect_valid=1.
  - redirect_pc = actual_takeM ? actual_targetM : head.pc+4, registered at the mispredict pop.
  - No push or pop occurs. Next state is RUN.
- flush_o and redirect_valid are registered and 1 only in FLUSH. A correct prediction produces no flush.
- Update port:
  - Registered, one cycle after every pop, including mispredicts.
  - upd_valid=1 for one cycle, with upd_pc = head.pc and upd_take = actual_takeM.
  - Otherwise upd_valid=0; upd_pc and upd_take hold their last value.
- Counters:
  - branch_cnt increments on every pop.
  - mispred_cnt increments on every mispredict pop.
  - Both saturate at all-ones, never wrap, and update in the cycle after the pop.
- rst mid-FLUSH aborts the flush: outputs go to 0 next cycle and the queue is emptied.
- q_err clears only on rst.

Test Plan:
- Correct taken prediction: push pc=0x100, take=1, tgt=0x200; later branchM with take=1, tgt=0x200 -> upd_valid pulse with upd_pc=0x100 and upd_take=1; flush_o stays 0; branch_cnt=1; mispred_cnt=0.
- Direction mispredict: push pc=0x104, take=0; branchM with take=1, tgt=0x300 -> next cycle flush_o=1, redirect_valid=1, redirect_pc=0x300; mispred_cnt=1; queue empty.
- Target mispredict plus wrong-path discard: push two entries (0x10 taken to 0x40, then 0x20); branchM take=1, tgt=0x80 with a simultaneous push of 0x30 -> redirect_pc=0x80; queue count=0 afterwards; 0x20 and 0x30 never produce upd_valid.
- Full and wrap: push QDEPTH entries -> q_full=1. A fifth push with no pop -> dropped and q_err=1. Then push and pop interleaved for 10 cycles -> FIFO order preserved across pointer wrap.
- Stall and flush gating: branchD=1 with stallD=1 for 3 cycles, then released -> exactly one entry pushed. branchD=1 with flushD=1 -> no entry pushed.
- Counter saturation and reset: with CNT_W=4, perform 20 correct pops -> branch_cnt=15. Assert rst during FLUSH -> next cycle flush_o=0, counters=0, q_err=0.
